cardio_mlp_seq: RTL
===================

# cardio_mlp_seq

Folded, sequential implementation of the cardio 21-feature, 3-hidden, 3-class MLP classifier. The datapath is a single time-shared signed multiply-accumulate unit, driven by a state machine that walks both layers and the argmax. Coefficients are held in an internal register file that is written through a configuration port. The block sits between the feature front-end (valid/ready) and the decision consumer (valid/ready). It replaces the fully parallel classifier where area matters more than latency.

## Interface
- No parameters; all dimensions are fixed: 21 features × 4 bits, 3 hidden neurons, 3 outputs.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: feature vector valid.
- `in_ready` out 1: high only in IDLE.
- `in_data` in 84: feature f is at bits [4f+3:4f], unsigned.
- `cfg_we` in 1: coefficient write strobe.
- `cfg_addr` in 7: coefficient address.
- `cfg_data` in 18: signed coefficient value.
- `cfg_ready` out 1: high only in IDLE.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_class` out 2: argmax index, 0..2.
- `out_scores` out 60: {o0, o1, o2}; each is 20 bits, unsigned, post-ReLU.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **Coefficient map** (78 entries):
  - 0..62: layer-0 weight at n·21+f.
  - 63..65: layer-0 bias for neuron n.
  - 66..74: layer-1 weight at j·3+i (j = output neuron, i = hidden neuron).
  - 75..77: layer-1 bias for neuron j.
- **Coefficient storage:**
  - Weights store cfg_data[7:0] as signed 8-bit.
  - Layer-0 biases store cfg_data[13:0] as signed 14-bit.
  - Layer-1 biases store all 18 bits, signed.
- **Coefficient writes:**
  - A write takes effect when `cfg_we` is high and the block is in IDLE.
  - Writes with address ≥78 are ignored.
  - Writes in any other state are ignored.
  - All entries reset to 0.
- **States:** IDLE → L0 → L1 → ARG → DONE → IDLE.
- **IDLE:** on `in_valid` high, capture `in_data` into an internal register and go to L0. Later changes to `in_data` have no effect.
- **L0:** 63 cycles, neuron n = 0..2, feature f = 0..20.
  - Product = {0, x_f} (5-bit signed) × w (8-bit) → 12-bit signed.
  - At f=0: acc = bias + product. Otherwise: acc = acc + product.
  - The accumulator is 14-bit signed and wraps modulo 2^14 (no saturation).
  - After f=20: h_n = 0 if acc < 0, else acc[12:0].
- **L1:** 9 cycles, neuron j = 0..2, hidden input i = 0..2.
  - Product = {0, h_i} (14-bit) × w (8-bit) → 21-bit signed.
  - The accumulator is 21-bit signed, seeded with the sign-extended bias at i=0.
  - After i=2: o_j = 0 if acc < 0, else acc[19:0].
- **ARG:** 1 cycle. Compute c = (o0 ≥ o1) ? 0 : 1, with v = max(o0, o1). Then class = (v ≥ o2) ? c : 2. Ties resolve to the lower index.
- **DONE:**
  - `out_valid` is high; `out_class` and `out_scores` are registered and stable.
  - On `out_valid` and `out_ready` both high, go to IDLE.
- **Concurrency:**
  - Only one vector is in flight; there is no overlap.
  - A `cfg_we` write in the same IDLE cycle as input acceptance lands at that edge, and the new value is used by the computation.
- **Reset (including mid-operation):**
  - Returns to IDLE.
  - Clears the coefficient file, accumulator and counters.
  - Output reset values: `out_valid`=0, `out_class`=0, `out_scores`=0, `busy`=0, `in_ready`=0 while `rst_n` is low, then 1.

## Timing
- Input acceptance occurs at edge E0.
- L0 occupies cycles 1–63, L1 occupies cycles 64–72, ARG occupies cycle 73.
- `out_valid` rises after edge E0+74. The fixed latency is 74 cycles.
- `in_ready` and `cfg_ready` are low from E0 until the edge after the output handshake.
- Minimum initiation interval is 75 cycles (output consumed in its first valid cycle, next vector accepted the following cycle).
- `out_class` and `out_scores` change only on entry to DONE. They hold until the next DONE; they are not cleared on return to IDLE.
- Under backpressure (`out_ready` low), DONE holds indefinitely with no output change.

## Test plan
- **Zero coefficients:** after reset, input 84'h0 or all-ones → scores 0/0/0, class 0, `out_valid` exactly 74 cycles after acceptance.
- **Simple path:** write 63:=5, 0:=2, 66:=3, 76:=1; input feature0=4, others 0 → h0=13, o0=39, o1=1, o2=0, class 0.
- **Layer-0 wrap:** addresses 0..20 := 127, 66:=1, all features 15 → sum 40005 wraps to h0=7237, o0=7237.
- **ReLU:**
  - 63:=−100, 77:=−5, 76:=7 → h0=0, o2=0, o1=7, class 1.
  - Tie case: 75..77 := 9 → class 0.
  - Tie case: 76=77=9, 75=0 → class 1.
- **Backpressure and lockout:** hold `out_ready` low for 10 cycles in DONE → outputs stable, `in_ready` and `cfg_ready` low, a cfg write to addr 75 is ignored (verified on the next vector). Also, addr 78 writes are ignored in IDLE.
- **Reset mid-L0 (cycle 30):** → IDLE next edge, `out_valid` 0, coefficients zero; the next vector yields class 0 with scores 0.

Source files
------------

// File: rtl/cardio_mlp_seq.sv
// cardio_mlp_seq
// Folded 21-feature / 3-hidden / 3-class MLP classifier. A single signed
// multiply-accumulate unit is time-shared across both layers under a small
// state machine (IDLE -> L0 -> L1 -> ARG -> DONE -> IDLE). Coefficients sit in
// an internal register file written through the cfg port while idle.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     feature vector handshake; in_ready high only in IDLE
//   in_data[83:0]         21 unsigned 4-bit features, feature f at [4f+3:4f]
//   cfg_we/addr/data      coefficient write port (78 entries), cfg_ready in IDLE
//   out_valid/out_ready   result handshake; out_valid high in DONE
//   out_class[1:0]        argmax index, ties resolve to the lower index
//   out_scores[59:0]      {o0, o1, o2}, 20-bit unsigned post-ReLU scores
//   busy                  high whenever not in IDLE
module cardio_mlp_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [83:0] in_data,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [17:0] cfg_data,
  output logic        cfg_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_class,
  output logic [59:0] out_scores,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L0   = 3'd1,
    L1   = 3'd2,
    ARG  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Coefficient file
  logic signed [7:0]  w0_q [63];
  logic signed [13:0] b0_q [3];
  logic signed [7:0]  w1_q [9];
  logic signed [17:0] b1_q [3];

  logic [83:0]        x_q;
  logic [1:0]         n_q;      // output neuron of the current layer
  logic [4:0]         f_q;      // input index of the current layer
  logic signed [20:0] acc_p1;
  logic [12:0]        h_q [3];
  logic [19:0]        o_q [3];
  logic [1:0]         class_q;
  logic [59:0]        scores_q;

  function automatic logic [12:0] relu_h(input logic signed [20:0] a);
    return a[20] ? 13'd0 : a[12:0];
  endfunction

  function automatic logic [19:0] relu_o(input logic signed [20:0] a);
    return a[20] ? 20'd0 : a[19:0];
  endfunction

  function automatic logic [1:0] argmax3(input logic [19:0] o0,
                                         input logic [19:0] o1,
                                         input logic [19:0] o2);
    logic [1:0]  c;
    logic [19:0] v;
    c = (o0 >= o1) ? 2'd0 : 2'd1;
    v = (o0 >= o1) ? o0 : o1;
    return (v >= o2) ? c : 2'd2;
  endfunction

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = L0;
      L0:   if (n_q == 2'd2 && f_q == 5'd20) state_d = L1;
      L1:   if (n_q == 2'd2 && f_q == 5'd2) state_d = ARG;
      ARG:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = rst_n && (state_q == IDLE);
  assign cfg_ready  = rst_n && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_class  = class_q;
  assign out_scores = scores_q;

  // ---------------------------------------------------------------- stage p0: operand select and multiply
  logic [5:0]         w0_idx;
  logic [3:0]         w1_idx;
  logic [6:0]         x_sel;
  logic [3:0]         x_f;
  logic signed [14:0] mul_a;
  logic signed [7:0]  mul_b;
  logic signed [20:0] prod_p0;
  logic signed [20:0] seed_p0;
  logic signed [20:0] sum_p0;
  logic signed [20:0] acc_d;

  assign w0_idx = 6'(n_q) * 6'd21 + 6'(f_q);
  assign w1_idx = 4'(n_q) * 4'd3 + 4'(f_q[1:0]);
  assign x_sel  = {f_q, 2'b00};
  assign x_f    = x_q[x_sel +: 4];

  always_comb begin
    if (state_q == L1) begin
      mul_a   = {2'b00, h_q[f_q[1:0]]};
      mul_b   = w1_q[w1_idx];
      seed_p0 = {{3{b1_q[n_q][17]}}, b1_q[n_q]};
    end else begin
      mul_a   = {11'd0, x_f};
      mul_b   = w0_q[w0_idx];
      seed_p0 = {{7{b0_q[n_q][13]}}, b0_q[n_q]};
    end
    // Both layer products fit in 21 bits, so a 21-bit product is exact.
    prod_p0 = mul_a * mul_b;
    sum_p0  = ((f_q == 5'd0) ? seed_p0 : acc_p1) + prod_p0;
    // Layer 0 accumulates modulo 2^14; keep it sign-extended in the shared register.
    if (state_q == L1) acc_d = sum_p0;
    else               acc_d = {{7{sum_p0[13]}}, sum_p0[13:0]};
  end

  logic [1:0] off_b0, off_b1;
  logic [3:0] off_w1;
  logic       cfg_wr;

  assign off_b0 = 2'(cfg_addr - 7'd63);
  assign off_w1 = 4'(cfg_addr - 7'd66);
  assign off_b1 = 2'(cfg_addr - 7'd75);
  assign cfg_wr = cfg_we && (state_q == IDLE);

  // ---------------------------------------------------------------- stage p1: accumulator, layer results, outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 63; i++) w0_q[i] <= '0;
      for (int i = 0; i < 9; i++)  w1_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        b0_q[i] <= '0;
        b1_q[i] <= '0;
        h_q[i]  <= '0;
        o_q[i]  <= '0;
      end
      x_q      <= '0;
      n_q      <= '0;
      f_q      <= '0;
      acc_p1   <= '0;
      class_q  <= '0;
      scores_q <= '0;
    end else begin
      if (cfg_wr) begin
        if (cfg_addr < 7'd63)      w0_q[cfg_addr[5:0]] <= cfg_data[7:0];
        else if (cfg_addr < 7'd66) b0_q[off_b0]        <= cfg_data[13:0];
        else if (cfg_addr < 7'd75) w1_q[off_w1]        <= cfg_data[7:0];
        else if (cfg_addr < 7'd78) b1_q[off_b1]        <= cfg_data;
      end

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q <= in_data;
            n_q <= '0;
            f_q <= '0;
          end
        end
        L0: begin
          acc_p1 <= acc_d;
          if (f_q == 5'd20) begin
            h_q[n_q] <= relu_h(acc_d);
            f_q      <= '0;
            n_q      <= (n_q == 2'd2) ? 2'd0 : n_q + 2'd1;
          end else begin
            f_q <= f_q + 5'd1;
          end
        end
        L1: begin
          acc_p1 <= acc_d;
          if (f_q == 5'd2) begin
            o_q[n_q] <= relu_o(acc_d);
            f_q      <= '0;
            n_q      <= (n_q == 2'd2) ? 2'd0 : n_q + 2'd1;
          end else begin
            f_q <= f_q + 5'd1;
          end
        end
        ARG: begin
          class_q  <= argmax3(o_q[0], o_q[1], o_q[2]);
          scores_q <= {o_q[0], o_q[1], o_q[2]};
        end
        default: ;
      endcase
    end
  end

endmodule
